// File: rtl/arb_pkt_mux_if.sv
// Bundle of source channels, arbiter request/grant and registered output of arb_pkt_mux.
// Latency: none; this is wiring only.
// Backpressure: carries in_ready/out_ready; slave is the mux view, master is the surrounding logic.
interface arb_pkt_mux_if #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 2
);
    logic [WIDTH-1:0]            in_valid;
    logic [WIDTH*DATA_WIDTH-1:0] in_data;
    logic [WIDTH-1:0]            in_last;
    logic [WIDTH-1:0]            in_ready;
    logic [WIDTH-1:0]            arb_req;
    logic [WIDTH-1:0]            arb_grant;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_last;
    logic [SRC_WIDTH-1:0]        out_src;
    logic                        out_ready;

    modport master (
        output in_valid, in_data, in_last, arb_grant, out_ready,
        input  in_ready, arb_req, out_valid, out_data, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, in_last, arb_grant, out_ready,
        output in_ready, arb_req, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/arb_pkt_mux.sv
// Packet-aware mux: turns WIDTH valid/ready channels into arbiter requests, registers the granted beat.
// Latency: 1 cycle from input handshake to out_valid; 1 beat/cycle under continuous out_ready.
// Backpressure: no request or accept while the output holds an unaccepted beat. ARB_PKT_MUX_LOCK_EN holds a channel to its last beat.
module arb_pkt_mux #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    arb_pkt_mux_if.slave bus
);
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [SRC_WIDTH-1:0]  out_src_q, out_src_d;

    logic                  load_en;
    logic [WIDTH-1:0]      gnt_lsb;
    logic [SRC_WIDTH-1:0]  gnt_idx;
    logic [SRC_WIDTH-1:0]  sel;
    logic                  xfer;
    logic [WIDTH-1:0]      arb_req;
    logic [WIDTH-1:0]      in_ready;

`ifdef ARB_PKT_MUX_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t               state_q, state_d;
    logic [SRC_WIDTH-1:0] lock_sel_q, lock_sel_d;
`endif

    assign load_en = ~out_valid_q | bus.out_ready;

    // A multi-hot grant is illegal; the lowest set bit wins so the mux stays well defined.
    assign gnt_lsb = bus.arb_grant & (~bus.arb_grant + WIDTH'(1));

    always_comb begin
        gnt_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bus.arb_grant[i]) gnt_idx = SRC_WIDTH'(i);
        end
    end

    always_comb begin
        arb_req  = '0;
        in_ready = '0;
        sel      = gnt_idx;
        xfer     = 1'b0;
`ifdef ARB_PKT_MUX_LOCK_EN
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (state_q == LOCKED) begin
            // Arbiter sees no request here, so a locked packet spends no credit.
            sel                  = lock_sel_q;
            in_ready[lock_sel_q] = load_en;
            xfer                 = bus.in_valid[lock_sel_q] & load_en;
            if (xfer && bus.in_last[lock_sel_q]) state_d = IDLE;
        end else begin
            arb_req  = bus.in_valid & {WIDTH{load_en}};
            in_ready = gnt_lsb & arb_req;
            xfer     = |in_ready;
            if (xfer && !bus.in_last[gnt_idx]) begin
                state_d    = LOCKED;
                lock_sel_d = gnt_idx;
            end
        end
`else
        arb_req  = bus.in_valid & {WIDTH{load_en}};
        in_ready = gnt_lsb & arb_req;
        xfer     = |in_ready;
`endif
        if (rst) begin
            arb_req  = '0;
            in_ready = '0;
            xfer     = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = bus.in_data[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
                out_last_d = bus.in_last[sel];
                out_src_d  = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef ARB_PKT_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end
`endif

    assign bus.arb_req   = arb_req;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed bench for arb_pkt_mux with a round-robin arbiter model and an output scoreboard.
// Expectations for packet locking follow ARB_PKT_MUX_LOCK_EN when it is defined.
`timescale 1ns/1ps
module tb_arb_pkt_mux;
    localparam int W  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [DW-1:0] data; logic last; logic [SW-1:0] src; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_pkt_mux_if #(.WIDTH(W), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

    arb_pkt_mux #(.WIDTH(W), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Arbiter model: round robin from rr_ptr, optional fixed priority for channel 0.
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] gidx;
    logic [W-1:0]  grant_m;
    bit            prio0 = 1'b0;
    int            credit_used = 0;

    always_comb begin
        grant_m = '0;
        gidx    = '0;
        if (prio0 && bus.arb_req[0]) begin
            grant_m = 4'b0001;
            gidx    = '0;
        end
        for (int k = 0; k < W; k++) begin
            if (grant_m == '0 && bus.arb_req[(int'(rr_ptr) + k) % W]) begin
                grant_m[(int'(rr_ptr) + k) % W] = 1'b1;
                gidx = SW'((int'(rr_ptr) + k) % W);
            end
        end
    end
    assign bus.arb_grant = grant_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (bus.arb_req != '0) begin
            credit_used <= credit_used + 1;
            if (grant_m != '0) rr_ptr <= SW'(gidx + 1'b1);
        end
    end

    beat_t        src_q [W][$];
    exp_t         exp_q [$];
    logic [W-1:0] en;
    logic [W-1:0] hs;
    int           total = 0;
    int           bad   = 0;
    int           snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < W; i++) begin
            if (src_q[i].size() > 0 && en[i]) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_data[i*DW +: DW]  = src_q[i][0].data;
                bus.in_last[i]           = src_q[i][0].last;
            end else begin
                bus.in_valid[i]          = 1'b0;
                bus.in_data[i*DW +: DW]  = '0;
                bus.in_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic push_src(input int ch, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[ch].push_back(b);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic [SW-1:0] s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    task automatic neg_sample();
        exp_t e;
        @(negedge clk);
        chk("grant_onehot", 64'($onehot0(bus.arb_grant)), 64'd1);
        hs = bus.in_valid & bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL extra_beat: observed src=%0d data=%0h expected no beat", bus.out_src, bus.out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e.data));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
                chk("out_src",  64'(bus.out_src),  64'(e.src));
            end
        end
    endtask

    task automatic post_edge();
        beat_t b;
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            if (hs[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
        end
        drive();
    endtask

    task automatic step();
        neg_sample();
        post_edge();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        en            = '1;
        prio0         = 1'b0;
        for (int i = 0; i < W; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, limit 50000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b1;
        en            = '1;
        hs            = '0;
        for (int i = 0; i < W; i++) push_src(i, DW'(32'h1000 + i), 1'b1);
        drive();

        // Reset held with every channel valid.
        repeat (3) begin
            @(negedge clk);
            chk("rst_arb_req",   64'(bus.arb_req),   64'h0);
            chk("rst_in_ready",  64'(bus.in_ready),  64'h0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
            chk("rst_out_data",  64'(bus.out_data),  64'h0);
            @(posedge clk);
        end

        // ch1 3-beat packet against pending ch0 single beats.
        do_reset();
        push_src(1, 32'hA000_0000, 1'b0);
        push_src(1, 32'hA000_0001, 1'b0);
        push_src(1, 32'hA000_0002, 1'b1);
        push_src(0, 32'hB000_0000, 1'b1);
        push_src(0, 32'hB000_0001, 1'b1);
`ifdef ARB_PKT_MUX_LOCK_EN
        push_exp(32'hA000_0000, 1'b0, 2'd1);
        push_exp(32'hA000_0001, 1'b0, 2'd1);
        push_exp(32'hA000_0002, 1'b1, 2'd1);
        push_exp(32'hB000_0000, 1'b1, 2'd0);
        push_exp(32'hB000_0001, 1'b1, 2'd0);
`else
        prio0 = 1'b1;
        push_exp(32'hA000_0000, 1'b0, 2'd1);
        push_exp(32'hB000_0000, 1'b1, 2'd0);
        push_exp(32'hB000_0001, 1'b1, 2'd0);
        push_exp(32'hA000_0001, 1'b0, 2'd1);
        push_exp(32'hA000_0002, 1'b1, 2'd1);
`endif
        en = 4'b0010;
        drive();
        neg_sample();
        chk("pkt_req_c0", 64'(bus.arb_req), 64'h2);
        post_edge();
        en = 4'b0011;
        drive();
        neg_sample();
`ifdef ARB_PKT_MUX_LOCK_EN
        chk("pkt_req_c1",   64'(bus.arb_req),  64'h0);
        chk("pkt_ready_c1", 64'(bus.in_ready), 64'h2);
`else
        chk("pkt_req_c1",   64'(bus.arb_req),  64'h3);
        chk("pkt_ready_c1", 64'(bus.in_ready), 64'h1);
`endif
        post_edge();
        neg_sample();
`ifdef ARB_PKT_MUX_LOCK_EN
        chk("pkt_req_c2", 64'(bus.arb_req), 64'h0);
`else
        chk("pkt_req_c2", 64'(bus.arb_req), 64'h3);
`endif
        post_edge();
        neg_sample();
`ifdef ARB_PKT_MUX_LOCK_EN
        chk("pkt_req_c3",   64'(bus.arb_req),  64'h1);
        chk("pkt_ready_c3", 64'(bus.in_ready), 64'h1);
`else
        chk("pkt_req_c3", 64'(bus.arb_req), 64'h2);
`endif
        post_edge();
        drain("pkt", 20);

        // Output stall with all channels valid.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < W; i++) begin
            push_src(i, DW'(32'h4000_0000 + i), 1'b1);
            push_exp(DW'(32'h4000_0000 + i), 1'b1, SW'(i));
        end
        drive();
        neg_sample();
        chk("stall_first_valid", 64'(bus.out_valid), 64'h0);
        post_edge();
        snap = credit_used;
        repeat (5) begin
            neg_sample();
            chk("stall_out_valid", 64'(bus.out_valid), 64'h1);
            chk("stall_arb_req",   64'(bus.arb_req),   64'h0);
            chk("stall_in_ready",  64'(bus.in_ready),  64'h0);
            chk("stall_out_data",  64'(bus.out_data),  64'h4000_0000);
            post_edge();
        end
        chk("stall_credit", 64'(credit_used), 64'(snap));
        bus.out_ready = 1'b1;
        drain("stall", 20);

        // Continuous single-beat traffic on all channels.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < W; i++) begin
                push_src(i, DW'(32'h5000_0000 + j * 16 + i), 1'b1);
                push_exp(DW'(32'h5000_0000 + j * 16 + i), 1'b1, SW'(i));
            end
        end
        drive();
        step();
        for (int k = 0; k < 12; k++) begin
            neg_sample();
            chk("stream_out_valid", 64'(bus.out_valid), 64'h1);
            post_edge();
        end
        chk("stream_done", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a ch2 packet, then a fresh ch3 request.
        do_reset();
        for (int i = 0; i < 4; i++) push_src(2, DW'(32'h6000_0000 + i), (i == 3));
        push_exp(32'h6000_0000, 1'b0, 2'd2);
        drive();
        step();
        step();
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        src_q[2].delete();
        push_src(3, 32'h6000_00E0, 1'b1);
        push_exp(32'h6000_00E0, 1'b1, 2'd3);
        drive();
        neg_sample();
        chk("midrst_arb_req",  64'(bus.arb_req),  64'h0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'h0);
        post_edge();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        neg_sample();
        chk("after_rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("after_rst_arb_req",   64'(bus.arb_req),   64'h8);
        chk("after_rst_in_ready",  64'(bus.in_ready),  64'h8);
        post_edge();
        drain("after_rst", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
